replay_issue_ctrl: RTL and testbench

Initiator-side controller for the valid/replay interface served by the comp-block responders. It accepts one request at a time from upstream, drives `io_valid`/`io_bits` to the responder array and samples the combinational `io_replay` in the same cycle. On replay it re-issues after a fixed backoff, up to a bounded retry count. It then returns a completion (ok or give-up error) to upstream over a ready/valid response port.

---
 rtl/replay_issue_ctrl.sv | 92 +++++++++
 tb/tb_replay_issue_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/replay_issue_ctrl.sv
// rtl/replay_issue_ctrl.sv - single-outstanding issue controller with bounded replay retry and backoff
module replay_issue_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 2,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
  localparam int BW = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_valid,
  output logic [WIDTH-1:0] io_bits,
  input  logic             io_replay,
  output logic             io_done_valid,
  input  logic             io_done_ready,
  output logic [WIDTH-1:0] io_done_bits,
  output logic             io_done_err,
  output logic [RW-1:0]    io_done_retries,
  output logic [15:0]      io_replay_total
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [RW-1:0]    retry_cnt;
  logic [BW-1:0]    bo_cnt;
  logic             err_q;
  logic [15:0]      replay_total;

  // Outputs decode directly from registered state, so none of them depend
  // combinationally on io_replay.
  assign io_enq_ready    = (state == S_IDLE);
  assign io_valid        = (state == S_ISSUE);
  assign io_bits         = data_q;
  assign io_done_valid   = (state == S_RESP);
  assign io_done_bits    = data_q;
  assign io_done_err     = err_q & (state == S_RESP);
  assign io_done_retries = retry_cnt;
  assign io_replay_total = replay_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      data_q       <= '0;
      retry_cnt    <= '0;
      bo_cnt       <= '0;
      err_q        <= 1'b0;
      replay_total <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io_enq_valid) begin
            data_q    <= io_enq_bits;
            retry_cnt <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!io_replay) begin
            err_q <= 1'b0;
            state <= S_RESP;
          end else begin
            if (replay_total != 16'hFFFF) replay_total <= replay_total + 16'd1;
            if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              if (BACKOFF > 0) begin
                bo_cnt <= BW'(BACKOFF);
                state  <= S_WAIT;
              end
            end else begin
              err_q <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          bo_cnt <= bo_cnt - 1'b1;
          if (bo_cnt == BW'(1)) state <= S_ISSUE;
        end
        S_RESP: begin
          if (io_done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_replay_issue_ctrl.sv
// tb/tb_replay_issue_ctrl.sv - directed self-checking bench for replay_issue_ctrl
module tb_replay_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_valid;
  logic [7:0] enq_bits;
  logic       replay;
  logic       done_ready;

  logic       a_enq_ready, a_valid, a_done_valid, a_done_err;
  logic [7:0] a_bits, a_done_bits;
  logic [1:0] a_done_retries;
  logic [15:0] a_total;

  logic       z_enq_ready, z_valid, z_done_valid, z_done_err;
  logic [7:0] z_bits, z_done_bits;
  logic [1:0] z_done_retries;
  logic [15:0] z_total;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  replay_issue_ctrl #(.WIDTH(8), .MAX_RETRY(3), .BACKOFF(2)) dut (
    .clk(clk), .reset(reset),
    .io_enq_valid(enq_valid), .io_enq_ready(a_enq_ready), .io_enq_bits(enq_bits),
    .io_valid(a_valid), .io_bits(a_bits), .io_replay(replay),
    .io_done_valid(a_done_valid), .io_done_ready(done_ready),
    .io_done_bits(a_done_bits), .io_done_err(a_done_err),
    .io_done_retries(a_done_retries), .io_replay_total(a_total)
  );

  replay_issue_ctrl #(.WIDTH(8), .MAX_RETRY(3), .BACKOFF(0)) dut0 (
    .clk(clk), .reset(reset),
    .io_enq_valid(enq_valid), .io_enq_ready(z_enq_ready), .io_enq_bits(enq_bits),
    .io_valid(z_valid), .io_bits(z_bits), .io_replay(replay),
    .io_done_valid(z_done_valid), .io_done_ready(done_ready),
    .io_done_bits(z_done_bits), .io_done_err(z_done_err),
    .io_done_retries(z_done_retries), .io_replay_total(z_total)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one request on the selected DUT, replay its first nrep issues and
  // return in the first cycle io_done_valid is seen (completion not yet taken).
  task automatic do_req(input logic sel, input logic [7:0] b, input int nrep,
                        output logic [15:0] vpat, output int ncyc);
    logic got;
    logic v;
    int   iss;
    vpat = '0;
    ncyc = 0;
    got  = 1'b0;
    iss  = 0;
    enq_valid = 1'b1;
    enq_bits  = b;
    tick();
    enq_valid = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (sel ? z_done_valid : a_done_valid) begin
        got = 1'b1;
      end else begin
        v = sel ? z_valid : a_valid;
        vpat = {vpat[14:0], v};
        ncyc++;
        if (v) begin
          chk("issue_bits", {24'd0, sel ? z_bits : a_bits}, {24'd0, b});
          replay = (iss < nrep);
          iss++;
        end else begin
          replay = 1'b0;
        end
        tick();
      end
    end
    replay = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
  endtask

  logic [15:0] pat;
  int          n;
  logic        seen;

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_bits = '0; replay = 1'b0; done_ready = 1'b1;
    do_reset();
    chk("rst_enq_ready", {31'd0, a_enq_ready}, 32'd1);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_done_valid", {31'd0, a_done_valid}, 32'd0);
    chk("rst_done_err", {31'd0, a_done_err}, 32'd0);
    chk("rst_bits", {24'd0, a_bits}, 32'd0);
    chk("rst_done_bits", {24'd0, a_done_bits}, 32'd0);
    chk("rst_retries", {30'd0, a_done_retries}, 32'd0);
    chk("rst_total", {16'd0, a_total}, 32'd0);

    // No replay: one issue cycle, done at t+2
    do_req(1'b0, 8'hA5, 0, pat, n);
    chk("t1_pat", {16'd0, pat}, 32'h1);
    chk("t1_len", n, 32'd1);
    chk("t1_bits", {24'd0, a_done_bits}, 32'hA5);
    chk("t1_err", {31'd0, a_done_err}, 32'd0);
    chk("t1_retries", {30'd0, a_done_retries}, 32'd0);
    tick();
    chk("t1_idle", {31'd0, a_enq_ready}, 32'd1);

    // One replay with BACKOFF=2: 1,0,0,1
    do_req(1'b0, 8'h3C, 1, pat, n);
    chk("t2_pat", {16'd0, pat}, 32'h9);
    chk("t2_len", n, 32'd4);
    chk("t2_err", {31'd0, a_done_err}, 32'd0);
    chk("t2_retries", {30'd0, a_done_retries}, 32'd1);
    chk("t2_total", {16'd0, a_total}, 32'd1);
    tick();

    // Replay held: 4 issues, give up; total accumulates across requests
    do_req(1'b0, 8'h77, 99, pat, n);
    chk("t3_pat", {16'd0, pat}, 32'h249);
    chk("t3_len", n, 32'd10);
    chk("t3_bits", {24'd0, a_done_bits}, 32'h77);
    chk("t3_err", {31'd0, a_done_err}, 32'd1);
    chk("t3_retries", {30'd0, a_done_retries}, 32'd3);
    chk("t3_total", {16'd0, a_total}, 32'd5);
    tick();

    // BACKOFF=0 instance: back-to-back issues
    do_reset();
    do_req(1'b1, 8'h11, 2, pat, n);
    chk("t4_pat", {16'd0, pat}, 32'h7);
    chk("t4_len", n, 32'd3);
    chk("t4_err", {31'd0, z_done_err}, 32'd0);
    chk("t4_retries", {30'd0, z_done_retries}, 32'd2);
    chk("t4_total", {16'd0, z_total}, 32'd2);
    tick();

    // Completion backpressure with a pending request upstream
    do_reset();
    done_ready = 1'b0;
    do_req(1'b0, 8'h5A, 0, pat, n);
    enq_valid = 1'b1;
    enq_bits  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_dv", {31'd0, a_done_valid}, 32'd1);
      chk("t5_hold_bits", {24'd0, a_done_bits}, 32'h5A);
      chk("t5_hold_rdy", {31'd0, a_enq_ready}, 32'd0);
      chk("t5_hold_iv", {31'd0, a_valid}, 32'd0);
    end
    done_ready = 1'b1;
    tick();
    chk("t5_rel_dv", {31'd0, a_done_valid}, 32'd0);
    chk("t5_rel_rdy", {31'd0, a_enq_ready}, 32'd1);
    chk("t5_rel_iv", {31'd0, a_valid}, 32'd0);
    tick();
    enq_valid = 1'b0;
    chk("t5_new_iv", {31'd0, a_valid}, 32'd1);
    chk("t5_new_bits", {24'd0, a_bits}, 32'hEE);
    tick();
    chk("t5_new_dv", {31'd0, a_done_valid}, 32'd1);
    tick();

    // Reset during the backoff after the 2nd replay
    do_reset();
    enq_valid = 1'b1; enq_bits = 8'h99;
    tick();
    enq_valid = 1'b0;
    chk("t6_iss1", {31'd0, a_valid}, 32'd1);
    replay = 1'b1;
    tick();
    replay = 1'b0;
    tick();
    tick();
    chk("t6_iss2", {31'd0, a_valid}, 32'd1);
    replay = 1'b1;
    tick();
    replay = 1'b0;
    chk("t6_wait", {31'd0, a_valid}, 32'd0);
    chk("t6_total_pre", {16'd0, a_total}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rdy", {31'd0, a_enq_ready}, 32'd1);
    chk("t6_iv", {31'd0, a_valid}, 32'd0);
    chk("t6_total", {16'd0, a_total}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | a_done_valid | a_valid;
      tick();
    end
    chk("t6_no_done", {31'd0, seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
